// File: rtl/ext_port_hub.sv
// ext_port_hub: N-channel extension-port controller.
// CPU requests are decoded by the top address bits into a channel. Writes are
// posted through a small FIFO. Reads wait until all earlier writes have drained.
// Each per-channel we/oe strobe is held for a programmable number of wait cycles.
module ext_port_hub #(
  parameter int N_CH         = 4,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 24,
  parameter int SEL_W        = 2,
  parameter int WFIFO_DEPTH  = 4,
  parameter int WAIT_W       = 4,
  parameter int DEFAULT_WAIT = 1
) (
  input  logic                   clk,
  input  logic                   r,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   err_sticky,
  input  logic                   cfg_we,
  input  logic [SEL_W-1:0]       cfg_ch,
  input  logic [WAIT_W-1:0]      cfg_wait,
  output logic [ADDR_W-1:0]      ep_addr,
  output logic [DATA_W-1:0]      ep_wdata,
  output logic [N_CH-1:0]        ep_we,
  output logic [N_CH-1:0]        ep_oe,
  input  logic [N_CH*DATA_W-1:0] ep_rdata
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);
  localparam logic [SEL_W:0] NCH_L = (SEL_W+1)'(N_CH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Decode a channel index into its strobe vector; zero for unimplemented channels.
  function automatic logic [N_CH-1:0] f_onehot(input logic [SEL_W-1:0] ch);
    logic [N_CH-1:0] v;
    v = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch == SEL_W'(k)) begin
        v[k] = 1'b1;
      end
    end
    return v;
  endfunction

  // Posted-write FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [ADDR_W-1:0] r_fifo_addr [WFIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [WFIFO_DEPTH];
  logic [PTR_W:0]    r_wptr;
  logic [PTR_W:0]    r_rptr;

  logic [WAIT_W-1:0] r_wait [N_CH];

  state_t            r_state;
  state_t            w_state_nx;
  logic [WAIT_W-1:0] r_cnt, w_cnt_nx;
  logic [SEL_W-1:0]  r_ch, w_ch_nx;
  logic              r_mapped, w_mapped_nx;
  logic [ADDR_W-1:0] r_ep_addr, w_addr_nx;
  logic [DATA_W-1:0] r_ep_wdata, w_wdata_nx;
  logic [N_CH-1:0]   r_ep_we, w_we_nx;
  logic [N_CH-1:0]   r_ep_oe, w_oe_nx;
  logic              r_rsp_valid, w_rsp_valid_nx;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nx;
  logic              r_rsp_err, w_rsp_err_nx;
  logic              r_err_sticky, w_err_nx;

  logic              w_full;
  logic              w_empty;
  logic              w_rd_ok;
  logic              w_push;
  logic              w_pop;
  logic              w_rd_acc;
  logic [ADDR_W-1:0] w_src_addr;
  logic [DATA_W-1:0] w_src_data;
  logic [SEL_W-1:0]  w_src_ch;
  logic              w_src_mapped;
  logic [WAIT_W-1:0] w_src_wait;
  logic [DATA_W-1:0] w_rd_slice;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

  // A read may only start once every posted write has been issued.
  assign w_rd_ok   = w_empty && (r_state == S_IDLE);
  assign req_ready = req_we ? !w_full : w_rd_ok;
  assign w_push    = req_valid && req_we && !w_full;
  assign w_rd_acc  = req_valid && !req_we && w_rd_ok;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;

  // A queued write always has priority over a new read when the FSM latches.
  assign w_src_addr   = w_pop ? r_fifo_addr[r_rptr[PTR_W-1:0]] : req_addr;
  assign w_src_data   = w_pop ? r_fifo_data[r_rptr[PTR_W-1:0]] : r_ep_wdata;
  assign w_src_ch     = w_src_addr[ADDR_W-1 -: SEL_W];
  assign w_src_mapped = ({1'b0, w_src_ch} < NCH_L);

  // Wait count for the access being latched, bypassing a same-edge cfg write
  always_comb begin
    w_src_wait = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_src_ch == SEL_W'(k)) begin
        if (cfg_we && (cfg_ch == w_src_ch)) begin
          w_src_wait = cfg_wait;
        end else begin
          w_src_wait = r_wait[k];
        end
      end
    end
  end

  // Select the read-data slice of the channel currently being read
  always_comb begin
    w_rd_slice = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (r_ch == SEL_W'(k)) begin
        w_rd_slice = ep_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO payload storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr[PTR_W-1:0]] <= req_addr;
      r_fifo_data[r_wptr[PTR_W-1:0]] <= req_wdata;
    end
  end

  // FIFO pointers; reset discards any pending writes
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (PTR_W+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (PTR_W+1)'(1);
      end
    end
  end

  // Per-channel wait registers; writes to unimplemented channels are dropped
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      for (int k = 0; k < N_CH; k++) begin
        r_wait[k] <= WAIT_W'(DEFAULT_WAIT);
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (cfg_we && (cfg_ch == SEL_W'(k))) begin
          r_wait[k] <= cfg_wait;
        end
      end
    end
  end

  // Next-state and next-output logic for the strobe sequencer
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_ch_nx        = r_ch;
    w_mapped_nx    = r_mapped;
    w_addr_nx      = r_ep_addr;
    w_wdata_nx     = r_ep_wdata;
    w_we_nx        = '0;
    w_oe_nx        = '0;
    w_rsp_valid_nx = 1'b0;
    w_rsp_rdata_nx = r_rsp_rdata;
    w_rsp_err_nx   = r_rsp_err;
    w_err_nx       = r_err_sticky;
    case (r_state)
      S_IDLE: begin
        if (w_pop || w_rd_acc) begin
          w_state_nx  = w_pop ? S_WR : S_RD;
          w_addr_nx   = w_src_addr;
          w_wdata_nx  = w_src_data;
          w_ch_nx     = w_src_ch;
          w_mapped_nx = w_src_mapped;
          if (w_src_mapped) begin
            w_cnt_nx = w_src_wait;
            if (w_pop) begin
              w_we_nx = f_onehot(w_src_ch);
            end else begin
              w_oe_nx = f_onehot(w_src_ch);
            end
          end else begin
            // Unmapped access: single cycle, no strobe, flag the error
            w_cnt_nx = '0;
            w_err_nx = 1'b1;
          end
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_WR: begin
        if (r_cnt == '0) begin
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt - WAIT_W'(1);
          w_we_nx  = r_mapped ? f_onehot(r_ch) : '0;
        end
      end
      S_RD: begin
        if (r_cnt == '0) begin
          w_state_nx     = S_RESP;
          w_rsp_valid_nx = 1'b1;
          w_rsp_rdata_nx = r_mapped ? w_rd_slice : '0;
          w_rsp_err_nx   = !r_mapped;
        end else begin
          w_cnt_nx = r_cnt - WAIT_W'(1);
          w_oe_nx  = r_mapped ? f_onehot(r_ch) : '0;
        end
      end
      S_RESP: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset drops strobes immediately
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ch         <= '0;
      r_mapped     <= 1'b0;
      r_ep_addr    <= '0;
      r_ep_wdata   <= '0;
      r_ep_we      <= '0;
      r_ep_oe      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_ch         <= w_ch_nx;
      r_mapped     <= w_mapped_nx;
      r_ep_addr    <= w_addr_nx;
      r_ep_wdata   <= w_wdata_nx;
      r_ep_we      <= w_we_nx;
      r_ep_oe      <= w_oe_nx;
      r_rsp_valid  <= w_rsp_valid_nx;
      r_rsp_rdata  <= w_rsp_rdata_nx;
      r_rsp_err    <= w_rsp_err_nx;
      r_err_sticky <= w_err_nx;
    end
  end

  assign ep_addr    = r_ep_addr;
  assign ep_wdata   = r_ep_wdata;
  assign ep_we      = r_ep_we;
  assign ep_oe      = r_ep_oe;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_ext_port_hub.sv
// Directed testbench for ext_port_hub. A default 4-channel instance carries
// most scenarios. A 3-channel instance shares the same inputs and is used for
// the unmapped-channel case.
module tb_ext_port_hub;

  logic        clk;
  logic        r;
  logic        req_valid;
  logic        req_we;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [3:0]  cfg_wait;
  logic [63:0] ep_rdata;

  logic        req_ready, rsp_valid, rsp_err, err_sticky;
  logic [15:0] rsp_rdata, ep_wdata;
  logic [23:0] ep_addr;
  logic [3:0]  ep_we, ep_oe;

  logic        d3_req_ready, d3_rsp_valid, d3_rsp_err, d3_err_sticky;
  logic [15:0] d3_rsp_rdata, d3_ep_wdata;
  logic [23:0] d3_ep_addr;
  logic [2:0]  d3_ep_we, d3_ep_oe;

  int checks   = 0;
  int failures = 0;

  logic [15:0] wq[$];
  logic        prev_we;

  ext_port_hub dut (
    .clk(clk), .r(r),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_sticky(err_sticky),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_wait(cfg_wait),
    .ep_addr(ep_addr), .ep_wdata(ep_wdata), .ep_we(ep_we), .ep_oe(ep_oe),
    .ep_rdata(ep_rdata)
  );

  ext_port_hub #(.N_CH(3)) dut3 (
    .clk(clk), .r(r),
    .req_valid(req_valid), .req_ready(d3_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(d3_rsp_valid), .rsp_rdata(d3_rsp_rdata), .rsp_err(d3_rsp_err),
    .err_sticky(d3_err_sticky),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_wait(cfg_wait),
    .ep_addr(d3_ep_addr), .ep_wdata(d3_ep_wdata), .ep_we(d3_ep_we), .ep_oe(d3_ep_oe),
    .ep_rdata(ep_rdata[47:0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record the write data at the start of every write strobe on the 4-channel instance
  always @(negedge clk) begin
    if ((ep_we != 4'b0000) && !prev_we) begin
      wq.push_back(ep_wdata);
    end
    prev_we <= (ep_we != 4'b0000);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic we, input logic [23:0] a, input logic [15:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    prev_we = 1'b0;
    r = 1'b1;
    set_req(1'b0, 1'b0, 24'h000000, 16'h0000);
    cfg_we = 1'b0; cfg_ch = 2'd0; cfg_wait = 4'd0;
    ep_rdata = {16'h3333, 16'h5A5A, 16'h1111, 16'h1234};

    // Reset state
    #3;
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_we", 32'(ep_we), 32'h0);
    chk("rst_oe", 32'(ep_oe), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_err_sticky", 32'(err_sticky), 32'h0);
    chk("rst_ep_addr", 32'(ep_addr), 32'h0);
    step(); step();
    r = 1'b0;

    // 1: single write to ch1, wait=1 -> 2-cycle strobe
    set_req(1'b1, 1'b1, 24'h400010, 16'hBEEF);
    #1 chk("t1_ready", 32'(req_ready), 32'h1);
    step();
    set_req(1'b0, 1'b0, 24'h000000, 16'h0000);
    chk("t1_we_c1", 32'(ep_we), 32'h0);
    step();
    chk("t1_we_c2", 32'(ep_we), 32'h2);
    chk("t1_addr", 32'(ep_addr), 32'h400010);
    chk("t1_wdata", 32'(ep_wdata), 32'hBEEF);
    step();
    chk("t1_we_c3", 32'(ep_we), 32'h2);
    step();
    chk("t1_we_end", 32'(ep_we), 32'h0);

    // 2: wait[0]=3, back-to-back writes fill the FIFO behind the first strobe
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_wait = 4'd3;
    step();
    cfg_we = 1'b0;
    wq.delete();
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 1'b1, 24'h000100 + 24'(i), 16'hA000 + 16'(i));
      #1 chk("t2_ready_acc", 32'(req_ready), 32'h1);
      step();
    end
    set_req(1'b1, 1'b1, 24'h000105, 16'hA005);
    #1 chk("t2_full_c5", 32'(req_ready), 32'h0);
    step();
    chk("t2_full_c6", 32'(req_ready), 32'h0);
    chk("t2_gap_we", 32'(ep_we), 32'h0);
    step();
    chk("t2_ready_after_pop", 32'(req_ready), 32'h1);
    chk("t2_we_after_pop", 32'(ep_we), 32'h1);
    step();
    set_req(1'b0, 1'b0, 24'h000000, 16'h0000);
    repeat (35) step();
    chk("t2_strobe_count", 32'(wq.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < wq.size()) begin
        chk("t2_strobe_order", 32'(wq[i]), 32'hA000 + 32'(i));
      end else begin
        chk("t2_strobe_missing", 32'h0, 32'hA000 + 32'(i));
      end
    end

    // 3: write ch2 then a read of ch2 waits for the write strobe to finish
    set_req(1'b1, 1'b1, 24'h800020, 16'hC0DE);
    #1 chk("t3_wr_ready", 32'(req_ready), 32'h1);
    step();
    set_req(1'b1, 1'b0, 24'h800024, 16'hFFFF);
    #1 chk("t3_rd_blk_c1", 32'(req_ready), 32'h0);
    step();
    chk("t3_we_c2", 32'(ep_we), 32'h4);
    chk("t3_rd_blk_c2", 32'(req_ready), 32'h0);
    step();
    chk("t3_we_c3", 32'(ep_we), 32'h4);
    chk("t3_rd_blk_c3", 32'(req_ready), 32'h0);
    step();
    chk("t3_we_c4", 32'(ep_we), 32'h0);
    chk("t3_rd_ready_c4", 32'(req_ready), 32'h1);
    step();
    set_req(1'b0, 1'b0, 24'h000000, 16'h0000);
    chk("t3_oe_c5", 32'(ep_oe), 32'h4);
    chk("t3_addr_c5", 32'(ep_addr), 32'h800024);
    chk("t3_wdata_held", 32'(ep_wdata), 32'hC0DE);
    step();
    chk("t3_oe_c6", 32'(ep_oe), 32'h4);
    chk("t3_rsp_early", 32'(rsp_valid), 32'h0);
    step();
    chk("t3_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t3_rsp_rdata", 32'(rsp_rdata), 32'h5A5A);
    chk("t3_rsp_err", 32'(rsp_err), 32'h0);
    chk("t3_oe_off", 32'(ep_oe), 32'h0);
    step();
    chk("t3_rsp_pulse", 32'(rsp_valid), 32'h0);

    // 4: wait[0]=0 written in the same edge the read is accepted
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_wait = 4'd0;
    set_req(1'b1, 1'b0, 24'h000040, 16'h0000);
    #1 chk("t4_ready", 32'(req_ready), 32'h1);
    step();
    cfg_we = 1'b0;
    set_req(1'b0, 1'b0, 24'h000000, 16'h0000);
    chk("t4_oe_e1", 32'(ep_oe), 32'h1);
    chk("t4_rsp_e1", 32'(rsp_valid), 32'h0);
    step();
    chk("t4_rsp_e2", 32'(rsp_valid), 32'h1);
    chk("t4_rdata", 32'(rsp_rdata), 32'h1234);
    chk("t4_err", 32'(rsp_err), 32'h0);
    chk("t4_oe_off", 32'(ep_oe), 32'h0);
    step();
    chk("t4_rsp_pulse", 32'(rsp_valid), 32'h0);

    // 5: read ch3 -- unmapped on the 3-channel instance, mapped on the 4-channel one
    chk("t5_sticky_before", 32'(d3_err_sticky), 32'h0);
    set_req(1'b1, 1'b0, 24'hC00000, 16'h0000);
    #1 chk("t5_ready", 32'(d3_req_ready), 32'h1);
    step();
    set_req(1'b0, 1'b0, 24'h000000, 16'h0000);
    chk("t5_d3_oe_c1", 32'(d3_ep_oe), 32'h0);
    chk("t5_d3_rsp_c1", 32'(d3_rsp_valid), 32'h0);
    chk("t5_oe4_c1", 32'(ep_oe), 32'h8);
    step();
    chk("t5_d3_rsp_valid", 32'(d3_rsp_valid), 32'h1);
    chk("t5_d3_rsp_err", 32'(d3_rsp_err), 32'h1);
    chk("t5_d3_rsp_rdata", 32'(d3_rsp_rdata), 32'h0);
    chk("t5_d3_sticky", 32'(d3_err_sticky), 32'h1);
    chk("t5_d3_oe_c2", 32'(d3_ep_oe), 32'h0);
    chk("t5_oe4_c2", 32'(ep_oe), 32'h8);
    chk("t5_sticky4", 32'(err_sticky), 32'h0);
    step();
    chk("t5_rsp4_valid", 32'(rsp_valid), 32'h1);
    chk("t5_rsp4_rdata", 32'(rsp_rdata), 32'h3333);
    chk("t5_d3_rsp_pulse", 32'(d3_rsp_valid), 32'h0);
    repeat (3) step();
    chk("t5_d3_sticky_hold", 32'(d3_err_sticky), 32'h1);

    // 6: reset during a 4-cycle write strobe with another write queued
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_wait = 4'd3;
    set_req(1'b1, 1'b1, 24'h400000, 16'h7777);
    step();
    cfg_we = 1'b0;
    set_req(1'b1, 1'b1, 24'h400004, 16'h8888);
    #1 chk("t6_ready_q", 32'(req_ready), 32'h1);
    step();
    set_req(1'b0, 1'b0, 24'h000000, 16'h0000);
    chk("t6_we_c2", 32'(ep_we), 32'h2);
    chk("t6_wdata", 32'(ep_wdata), 32'h7777);
    step();
    chk("t6_we_c3", 32'(ep_we), 32'h2);
    #2 r = 1'b1;
    #1;
    chk("t6_we_async", 32'(ep_we), 32'h0);
    chk("t6_oe_async", 32'(ep_oe), 32'h0);
    chk("t6_d3_sticky_clr", 32'(d3_err_sticky), 32'h0);
    set_req(1'b1, 1'b0, 24'h400000, 16'h0000);
    #1 chk("t6_ready_rd_rst", 32'(req_ready), 32'h1);
    step();
    r = 1'b0;
    #1 chk("t6_fifo_empty", 32'(req_ready), 32'h1);
    step();
    set_req(1'b0, 1'b0, 24'h000000, 16'h0000);
    chk("t6_oe_c1", 32'(ep_oe), 32'h2);
    chk("t6_no_we", 32'(ep_we), 32'h0);
    step();
    chk("t6_oe_c2", 32'(ep_oe), 32'h2);
    step();
    chk("t6_oe_off", 32'(ep_oe), 32'h0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t6_rsp_rdata", 32'(rsp_rdata), 32'h1111);
    step();
    chk("t6_no_we_after", 32'(ep_we), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
